// File: rtl/tinyqv_isa_pkg.sv
// rtl/tinyqv_isa_pkg.sv - shared tinyQV ISA constants: instruction classes, opcodes, NOP, shift funct3
package tinyqv_isa_pkg;

    typedef enum logic [3:0] {
        CLS_LOAD    = 4'd0,
        CLS_ALU_IMM = 4'd1,
        CLS_AUIPC   = 4'd2,
        CLS_STORE   = 4'd3,
        CLS_ALU_REG = 4'd4,
        CLS_LUI     = 4'd5,
        CLS_BRANCH  = 4'd6,
        CLS_JALR    = 4'd7,
        CLS_JAL     = 4'd8,
        CLS_SYSTEM  = 4'd9
    } instr_class_e;

    localparam logic [4:0] OP_LOAD    = 5'b00000;
    localparam logic [4:0] OP_ALU_IMM = 5'b00100;
    localparam logic [4:0] OP_AUIPC   = 5'b00101;
    localparam logic [4:0] OP_STORE   = 5'b01000;
    localparam logic [4:0] OP_ALU_REG = 5'b01100;
    localparam logic [4:0] OP_LUI     = 5'b01101;
    localparam logic [4:0] OP_BRANCH  = 5'b11000;
    localparam logic [4:0] OP_JALR    = 5'b11001;
    localparam logic [4:0] OP_JAL     = 5'b11011;
    localparam logic [4:0] OP_SYSTEM  = 5'b11100;

    localparam logic [31:0] NOP = 32'h00000013;

    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;

    // Major opcode bits [6:2]; illegal classes map to 0 and are rejected elsewhere
    function automatic logic [4:0] class_opcode(input instr_class_e cls);
        case (cls)
            CLS_LOAD:    return OP_LOAD;
            CLS_ALU_IMM: return OP_ALU_IMM;
            CLS_AUIPC:   return OP_AUIPC;
            CLS_STORE:   return OP_STORE;
            CLS_ALU_REG: return OP_ALU_REG;
            CLS_LUI:     return OP_LUI;
            CLS_BRANCH:  return OP_BRANCH;
            CLS_JALR:    return OP_JALR;
            CLS_JAL:     return OP_JAL;
            CLS_SYSTEM:  return OP_SYSTEM;
            default:     return 5'b00000;
        endcase
    endfunction

    function automatic logic is_shift_f3(input logic [2:0] funct3);
        return (funct3 == F3_SLL) || (funct3 == F3_SRL_SRA);
    endfunction

endpackage

// File: rtl/tinyqv_instr_encoder_if.sv
// rtl/tinyqv_instr_encoder_if.sv - descriptor input and nibble output handshake bundle
interface tinyqv_instr_encoder_if #(
    parameter int REG_ADDR_BITS = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [3:0]               in_class;
    logic [2:0]               in_funct3;
    logic                     in_alt;
    logic [REG_ADDR_BITS-1:0] in_rd;
    logic [REG_ADDR_BITS-1:0] in_rs1;
    logic [REG_ADDR_BITS-1:0] in_rs2;
    logic [31:0]              in_imm;
    logic                     out_valid;
    logic                     out_ready;
    logic [3:0]               out_nibble;
    logic                     out_first;
    logic                     out_last;
    logic                     out_err;

    modport master (
        output in_valid, in_class, in_funct3, in_alt, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        input  in_ready, out_valid, out_nibble, out_first, out_last, out_err
    );

    modport slave (
        input  in_valid, in_class, in_funct3, in_alt, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        output in_ready, out_valid, out_nibble, out_first, out_last, out_err
    );
endinterface

// File: rtl/tinyqv_imm_pack.sv
// rtl/tinyqv_imm_pack.sv - places the immediate into I/S/B/U/J bit positions and flags unencodable values
module tinyqv_imm_pack
    import tinyqv_isa_pkg::*;
(
    input  instr_class_e cls,
    input  logic [2:0]   funct3,
    input  logic [31:0]  imm,
    output logic [31:0]  imm_bits,
    output logic         range_err
);

    logic fits_i;
    logic fits_b;
    logic fits_j;

    // Sign-extension checks: every bit above the field's sign bit must copy it
    assign fits_i = (imm[31:11] == {21{imm[11]}});
    assign fits_b = (imm[31:12] == {20{imm[12]}}) && !imm[0];
    assign fits_j = (imm[31:20] == {12{imm[20]}}) && !imm[0];

    // Immediate scatter per class; non-immediate bits stay zero for the top to fill
    always_comb begin
        imm_bits  = '0;
        range_err = 1'b0;
        case (cls)
            CLS_LOAD, CLS_JALR, CLS_SYSTEM: begin
                imm_bits[31:20] = imm[11:0];
                range_err       = !fits_i;
            end
            CLS_ALU_IMM: begin
                if (is_shift_f3(funct3)) begin
                    imm_bits[24:20] = imm[4:0];
                    range_err       = |imm[31:5];
                end else begin
                    imm_bits[31:20] = imm[11:0];
                    range_err       = !fits_i;
                end
            end
            CLS_STORE: begin
                imm_bits[31:25] = imm[11:5];
                imm_bits[11:7]  = imm[4:0];
                range_err       = !fits_i;
            end
            CLS_BRANCH: begin
                imm_bits[31]    = imm[12];
                imm_bits[30:25] = imm[10:5];
                imm_bits[11:8]  = imm[4:1];
                imm_bits[7]     = imm[11];
                range_err       = !fits_b;
            end
            CLS_AUIPC, CLS_LUI: begin
                imm_bits[31:12] = imm[31:12];
                range_err       = |imm[11:0];
            end
            CLS_JAL: begin
                imm_bits[31]    = imm[20];
                imm_bits[30:21] = imm[10:1];
                imm_bits[20]    = imm[11];
                imm_bits[19:12] = imm[19:12];
                range_err       = !fits_j;
            end
            CLS_ALU_REG: begin
                range_err = 1'b0;
            end
            default: begin
                range_err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/tinyqv_instr_encoder.sv
// rtl/tinyqv_instr_encoder.sv - packs an instruction descriptor into a 32-bit word and streams it LSB nibble first
module tinyqv_instr_encoder
    import tinyqv_isa_pkg::*;
#(
    parameter int REG_ADDR_BITS = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    tinyqv_instr_encoder_if.slave bus
);

    instr_class_e             cls;
    logic [REG_ADDR_BITS-1:0] rd_idx;
    logic [REG_ADDR_BITS-1:0] rs1_idx;
    logic [REG_ADDR_BITS-1:0] rs2_idx;
    logic [4:0]               rd5;
    logic [4:0]               rs1_5;
    logic [4:0]               rs2_5;
    logic [31:0]              imm_bits;
    logic                     range_err;
    logic [31:0]              enc_word;
    logic                     enc_err;

    logic [31:0]              word;
    logic                     full;
    logic [2:0]               cnt;
    logic                     err;
    logic                     accept;
    logic                     out_hs;

    assign cls     = instr_class_e'(bus.in_class);
    assign rd_idx  = bus.in_rd;
    assign rs1_idx = bus.in_rs1;
    assign rs2_idx = bus.in_rs2;
    assign rd5     = 5'(rd_idx);
    assign rs1_5   = 5'(rs1_idx);
    assign rs2_5   = 5'(rs2_idx);

    tinyqv_imm_pack u_imm_pack (
        .cls       (cls),
        .funct3    (bus.in_funct3),
        .imm       (bus.in_imm),
        .imm_bits  (imm_bits),
        .range_err (range_err)
    );

    // Overlay opcode and register fields on the packed immediate; errors collapse to NOP
    always_comb begin
        enc_word      = imm_bits;
        enc_word[6:0] = {class_opcode(cls), 2'b11};
        case (cls)
            CLS_STORE, CLS_BRANCH: ;
            default: enc_word[11:7] = rd5;
        endcase
        case (cls)
            CLS_LUI, CLS_AUIPC, CLS_JAL: ;
            default: begin
                enc_word[19:15] = rs1_5;
                enc_word[14:12] = bus.in_funct3;
            end
        endcase
        case (cls)
            CLS_STORE, CLS_BRANCH, CLS_ALU_REG: enc_word[24:20] = rs2_5;
            default: ;
        endcase
        if (cls == CLS_ALU_REG) begin
            enc_word[30] = bus.in_alt;
        end
        if ((cls == CLS_ALU_IMM) && (bus.in_funct3 == F3_SRL_SRA)) begin
            enc_word[30] = bus.in_alt;
        end
        enc_err = range_err;
        if (range_err) begin
            enc_word = NOP;
        end
    end

    // Free the slot either when empty or while the last nibble leaves, so words run back to back
    assign out_hs       = full && bus.out_ready;
    assign bus.in_ready = !full || (out_hs && (cnt == 3'd7));
    assign accept       = bus.in_valid && bus.in_ready;

    assign bus.out_valid  = full;
    assign bus.out_nibble = word[{cnt, 2'b00} +: 4];
    assign bus.out_first  = (cnt == 3'd0);
    assign bus.out_last   = (cnt == 3'd7);
    assign bus.out_err    = err;

    // Holding register, occupancy and nibble position; a reload takes priority over draining
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            word <= '0;
            full <= 1'b0;
            cnt  <= 3'd0;
            err  <= 1'b0;
        end else if (accept) begin
            word <= enc_word;
            err  <= enc_err;
            full <= 1'b1;
            cnt  <= 3'd0;
        end else if (out_hs) begin
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) begin
                full <= 1'b0;
                err  <= 1'b0;
            end
        end
    end

endmodule
